// File: rtl/program_sequencer.sv
// program_sequencer: instruction fetch/issue controller for the 8-bit processor.
// Owns the PC, drives the combinational instruction memory address, captures
// each instruction and issues it over a valid/ready handshake. Resolves
// JMP/BR, CALL/RET through an internal return stack, and HALT.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_i; FETCH waits on it).
module program_sequencer #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    input  logic       start_i,
    output logic [7:0] imem_addr_o,
    input  logic [3:0] imem_op_i,
    input  logic [1:0] imem_ra_i,
    input  logic [1:0] imem_rb_i,
    input  logic       imem_brx_i,
    input  logic [7:0] imem_ea_i,
    input  logic       cond_i,
    output logic       issue_valid_o,
    input  logic       exec_ready_i,
    output logic [3:0] op_o,
    output logic [1:0] ra_o,
    output logic [1:0] rb_o,
    output logic [7:0] ea_o,
    output logic [7:0] pc_o,
    output logic       halted_o,
    output logic       stack_err_o
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int IX_W = SP_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_e;

    state_e          state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic [7:0]      ipc_q, ipc_d;
    logic [3:0]      op_q, op_d;
    logic [1:0]      ra_q, ra_d;
    logic [1:0]      rb_q, rb_d;
    logic            brx_q, brx_d;
    logic [7:0]      ea_q, ea_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;

    logic [7:0]      stack_q [STACK_DEPTH];
    logic            push_en;
    logic [IX_W-1:0] push_idx;
    logic [IX_W-1:0] pop_idx;
    logic            fetch_go;
    logic            handshake;

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go = step_i;
`else
    assign fetch_go = 1'b1;
`endif

    assign handshake = (state_q == S_ISSUE) && exec_ready_i;
    assign push_idx  = sp_q[IX_W-1:0];
    assign pop_idx   = push_idx - 1'b1;

    // Next-state, next-PC and return-stack control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        brx_d   = brx_q;
        ea_d    = ea_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    op_d    = imem_op_i;
                    ra_d    = imem_ra_i;
                    rb_d    = imem_rb_i;
                    brx_d   = imem_brx_i;
                    ea_d    = imem_ea_i;
                    ipc_d   = pc_q;
                    // HALT is never presented to the datapath.
                    state_d = (imem_op_i == 4'hF) ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    state_d = S_FETCH;
                    if (op_q[3] == 1'b0) begin
                        pc_d = pc_q + 8'd1;
                    end else if (op_q[3:2] == 2'b10) begin
                        pc_d = pc_q + 8'd2;
                    end else begin
                        unique case (op_q[1:0])
                            2'b00: pc_d = (!brx_q || cond_i) ? ea_q : pc_q + 8'd2;
                            2'b01: begin
                                if (sp_q == SP_W'(STACK_DEPTH)) begin
                                    err_d   = 1'b1;
                                    state_d = S_HALT;
                                end else begin
                                    push_en = 1'b1;
                                    sp_d    = sp_q + 1'b1;
                                    pc_d    = ea_q;
                                end
                            end
                            2'b10: begin
                                if (sp_q == '0) begin
                                    err_d   = 1'b1;
                                    state_d = S_HALT;
                                end else begin
                                    sp_d = sp_q - 1'b1;
                                    pc_d = stack_q[pop_idx];
                                end
                            end
                            default: state_d = S_HALT;
                        endcase
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Control and issue-field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            brx_q   <= 1'b0;
            ea_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            brx_q   <= brx_d;
            ea_q    <= ea_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage.
    // NOTE: the stack array has no reset; sp gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= pc_q + 8'd2;
    end

    assign imem_addr_o   = pc_q;
    assign issue_valid_o = (state_q == S_ISSUE);
    assign halted_o      = (state_q == S_HALT);
    assign stack_err_o   = err_q;
    assign op_o          = op_q;
    assign ra_o          = ra_q;
    assign rb_o          = rb_q;
    assign ea_o          = ea_q;
    assign pc_o          = ipc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: directed programs in a memory model,
// expected issues queued up front, a monitor pops and compares on each handshake.
module tb_program_sequencer;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
    } issue_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] imem_addr_o;
    logic       cond_i = 1'b0;
    logic       exec_ready_i = 1'b1;
    logic       issue_valid_o;
    logic [3:0] op_o;
    logic [1:0] ra_o, rb_o;
    logic [7:0] ea_o, pc_o;
    logic       halted_o, stack_err_o;

    logic [7:0] mem [256];
    logic [7:0] cur_word, ea_addr;
    issue_t     exp_q [$];
    int         total = 0;
    int         bad = 0;

    assign cur_word = mem[imem_addr_o];
    assign ea_addr  = imem_addr_o + 8'd1;

    program_sequencer #(.STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .imem_addr_o  (imem_addr_o),
        .imem_op_i    (cur_word[7:4]),
        .imem_ra_i    (cur_word[3:2]),
        .imem_rb_i    (cur_word[1:0]),
        .imem_brx_i   (cur_word[3]),
        .imem_ea_i    (mem[ea_addr]),
        .cond_i       (cond_i),
        .issue_valid_o(issue_valid_o),
        .exec_ready_i (exec_ready_i),
        .op_o         (op_o),
        .ra_o         (ra_o),
        .rb_o         (rb_o),
        .ea_o         (ea_o),
        .pc_o         (pc_o),
        .halted_o     (halted_o),
        .stack_err_o  (stack_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n && issue_valid_o && exec_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {8'h0, pc_o, op_o, ra_o, rb_o, ea_o}, 32'hFFFF_FFFF);
            end else begin
                issue_t e;
                e = exp_q.pop_front();
                check("issue", {8'h0, pc_o, op_o, ra_o, rb_o, ea_o}, {8'h0, e});
            end
        end
    end

    function automatic issue_t mk(input logic [7:0] pc, input logic [7:0] word, input logic [7:0] ea);
        issue_t t;
        t.pc = pc; t.op = word[7:4]; t.ra = word[3:2]; t.rb = word[1:0]; t.ea = ea;
        return t;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        exec_ready_i = 1'b1;
        cond_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        #3;
        check("rst_outs", {9'h0, issue_valid_o, halted_o, stack_err_o, op_o, ra_o, rb_o, ea_o, pc_o}, 32'h0);
        check("rst_addr", {24'h0, imem_addr_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 60; i++) begin
            if (halted_o) break;
            @(posedge clk); #1;
        end
        check(name, {31'h0, halted_o}, 32'h1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (issue_valid_o) break;
            @(posedge clk); #1;
        end
        check("wait_valid", {31'h0, issue_valid_o}, 32'h1);
    endtask

    initial begin
        // Straight line.
        do_reset();
        mem[0] = 8'h15; mem[1] = 8'h26;
        exp_q.push_back(mk(8'h00, 8'h15, 8'h26));
        exp_q.push_back(mk(8'h01, 8'h26, 8'hF0));
        pulse_start();
        wait_halt("line_halt");
        check("line_err", {31'h0, stack_err_o}, 32'h0);
        check("line_valid_off", {31'h0, issue_valid_o}, 32'h0);

        // Two-byte operand with backpressure.
        do_reset();
        mem[0] = 8'h84; mem[1] = 8'h40;
        exec_ready_i = 1'b0;
        exp_q.push_back(mk(8'h00, 8'h84, 8'h40));
        pulse_start();
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {15'h0, issue_valid_o, op_o, ea_o, pc_o}, {15'h0, 1'b1, 4'h8, 8'h40, 8'h00});
            @(posedge clk); #1;
        end
        exec_ready_i = 1'b1;
        wait_halt("bp_halt");
        check("bp_next_pc", {24'h0, imem_addr_o}, 32'h02);

        // Conditional branch taken, not taken, and unconditional jump.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            mem[0] = (v == 2) ? 8'hC0 : 8'hC8; mem[1] = 8'h20;
            mem[8'h20] = 8'h07; mem[8'h02] = 8'h07;
            cond_i = (v == 0);
            exp_q.push_back(mk(8'h00, mem[0], 8'h20));
            if (v == 1) exp_q.push_back(mk(8'h02, 8'h07, 8'hF0));
            else        exp_q.push_back(mk(8'h20, 8'h07, 8'hF0));
            pulse_start();
            wait_halt("branch_halt");
        end

        // CALL / RET.
        do_reset();
        mem[0] = 8'hC0; mem[1] = 8'h10;
        mem[8'h10] = 8'hD0; mem[8'h11] = 8'h50;
        mem[8'h50] = 8'hE0;
        mem[8'h12] = 8'h00;
        exp_q.push_back(mk(8'h00, 8'hC0, 8'h10));
        exp_q.push_back(mk(8'h10, 8'hD0, 8'h50));
        exp_q.push_back(mk(8'h50, 8'hE0, 8'hF0));
        exp_q.push_back(mk(8'h12, 8'h00, 8'hF0));
        pulse_start();
        wait_halt("call_halt");
        check("call_err", {31'h0, stack_err_o}, 32'h0);
        check("call_end_pc", {24'h0, imem_addr_o}, 32'h13);

        // Five nested CALLs overflow a 4-deep stack.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem[4*k]   = 8'hD0;
            mem[4*k+1] = 8'(4*k + 4);
            exp_q.push_back(mk(8'(4*k), 8'hD0, 8'(4*k + 4)));
        end
        pulse_start();
        wait_halt("ovf_halt");
        check("ovf_err", {31'h0, stack_err_o}, 32'h1);

        // RET with empty stack.
        do_reset();
        mem[0] = 8'hE0;
        exp_q.push_back(mk(8'h00, 8'hE0, 8'hF0));
        pulse_start();
        wait_halt("unf_halt");
        check("unf_err", {31'h0, stack_err_o}, 32'h1);

        // Reset in the middle of ISSUE.
        do_reset();
        mem[0] = 8'h84; mem[1] = 8'h40;
        exec_ready_i = 1'b0;
        pulse_start();
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", {9'h0, issue_valid_o, halted_o, stack_err_o, op_o, ra_o, rb_o, ea_o, pc_o}, 32'h0);
        check("midrst_addr", {24'h0, imem_addr_o}, 32'h0);

        // Two-byte op at 8'hFF wraps for ea and next PC.
        do_reset();
        mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h84;
        exp_q.push_back(mk(8'h00, 8'hC0, 8'hFF));
        exp_q.push_back(mk(8'hFF, 8'h84, 8'hC0));
        pulse_start();
        wait_halt("wrap_halt");
        check("wrap_next_pc", {24'h0, imem_addr_o}, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
